execute_stage: RTL



---
 rtl/execute_stage_if.sv | 43 ++++
 rtl/execute_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/execute_stage_if.sv
// Execute-stage bus: E_* pipeline-register inputs, downstream statuses, and the
// combinational e_* / registered M_* outputs of the execute stage.
interface execute_stage_if;
    logic [1:0]  E_status;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [3:0]  E_dste;
    logic [3:0]  E_dstm;
    logic [63:0] E_vala;
    logic [63:0] E_valb;
    logic [63:0] E_valc;
    logic [1:0]  m_status;
    logic [1:0]  W_status;
    logic        M_bubble;

    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_cnd;
    logic [2:0]  cc;

    logic [1:0]  M_status;
    logic [3:0]  M_icode;
    logic [3:0]  M_ifun;
    logic [3:0]  M_dste;
    logic [3:0]  M_dstm;
    logic        M_cnd;
    logic [63:0] M_vale;
    logic [63:0] M_vala;

    modport master (
        output E_status, E_icode, E_ifun, E_dste, E_dstm, E_vala, E_valb, E_valc,
               m_status, W_status, M_bubble,
        input  e_valE, e_dstE, e_cnd, cc,
               M_status, M_icode, M_ifun, M_dste, M_dstm, M_cnd, M_vale, M_vala
    );

    modport slave (
        input  E_status, E_icode, E_ifun, E_dste, E_dstm, E_vala, E_valb, E_valc,
               m_status, W_status, M_bubble,
        output e_valE, e_dstE, e_cnd, cc,
               M_status, M_icode, M_ifun, M_dste, M_dstm, M_cnd, M_vale, M_vala
    );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, {ZF,SF,OF} condition codes, cmov/jXX condition and M register.
// Define EXEC_MUL_EN to enable OPq ifun 4 (mulq); otherwise that encoding traps as INS.
module execute_stage #(
    parameter logic [2:0] CC_RESET_VAL = 3'b100,
    parameter logic [3:0] NOP_ICODE    = 4'h1,
    parameter logic [3:0] RNONE        = 4'hF
) (
    input logic           clock,
    input logic           reset_n,
    execute_stage_if.slave bus
);

    localparam logic [3:0] I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4,
                           I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
                           I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA,
                           I_POPQ   = 4'hB;
    localparam logic [1:0] S_AOK = 2'd0, S_INS = 2'd3;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_MUL, ALU_BAD} alu_fn_e;

    typedef struct packed {
        logic [1:0]  status;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{status: S_AOK, icode: NOP_ICODE, ifun: 4'h0, cnd: 1'b0,
                                    vale: 64'd0, vala: 64'd0, dste: RNONE, dstm: RNONE};

    logic [63:0] alu_a, alu_b, alu_res;
    logic        alu_of, op_valid, cond, cnd;
    alu_fn_e     alu_fn;
    logic [2:0]  cc_d, cc_q;
    m_reg_t      m_d, m_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_a = 64'd0;
        alu_b = 64'd0;
        alu_fn = ALU_ADD;
        case (bus.E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = bus.E_vala;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = bus.E_valc;
            I_CALL, I_PUSHQ:             alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:               alu_a = 64'd8;
            default:                     alu_a = 64'd0;
        endcase
        case (bus.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = bus.E_valb;
            default:                                                   alu_b = 64'd0;
        endcase
        if (bus.E_icode == I_OPQ) begin
            case (bus.E_ifun)
                4'h0:    alu_fn = ALU_ADD;
                4'h1:    alu_fn = ALU_SUB;
                4'h2:    alu_fn = ALU_AND;
                4'h3:    alu_fn = ALU_XOR;
`ifdef EXEC_MUL_EN
                4'h4:    alu_fn = ALU_MUL;
`endif
                default: alu_fn = ALU_BAD;
            endcase
        end
    end

`ifdef EXEC_MUL_EN
    logic [127:0] mul_prod;
    // Low 128 bits of the product of sign-extended operands equal the signed product.
    assign mul_prod = {{64{alu_b[63]}}, alu_b} * {{64{alu_a[63]}}, alu_a};
`endif

    always_comb begin
        alu_res = 64'd0;
        alu_of  = 1'b0;
        case (alu_fn)
            ALU_ADD: begin
                alu_res = alu_b + alu_a;
                alu_of  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
            end
            ALU_SUB: begin
                alu_res = alu_b - alu_a;
                alu_of  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
            end
            ALU_AND: alu_res = alu_b & alu_a;
            ALU_XOR: alu_res = alu_b ^ alu_a;
`ifdef EXEC_MUL_EN
            ALU_MUL: begin
                alu_res = mul_prod[63:0];
                alu_of  = mul_prod[127:64] != {64{mul_prod[63]}};
            end
`endif
            default: alu_res = 64'd0;
        endcase
    end

    assign op_valid = (alu_fn != ALU_BAD);

    always_comb begin
        cond = 1'b0;
        case (bus.E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2:    cond = cc_q[1] ^ cc_q[0];
            4'h3:    cond = cc_q[2];
            4'h4:    cond = ~cc_q[2];
            4'h5:    cond = ~(cc_q[1] ^ cc_q[0]);
            4'h6:    cond = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: cond = 1'b0;
        endcase
    end

    assign cnd = ((bus.E_icode == I_RRMOVQ) || (bus.E_icode == I_JXX)) && cond;

    always_comb begin
        cc_d = cc_q;
        if (bus.E_icode == I_OPQ && op_valid && bus.E_status == S_AOK &&
            bus.m_status == S_AOK && bus.W_status == S_AOK)
            cc_d = {alu_res == 64'd0, alu_res[63], alu_of};

        m_d = M_BUBBLE;
        if (!bus.M_bubble) begin
            m_d.status = op_valid ? bus.E_status : S_INS;
            m_d.icode  = bus.E_icode;
            m_d.ifun   = bus.E_ifun;
            m_d.cnd    = cnd;
            m_d.vale   = alu_res;
            m_d.vala   = bus.E_vala;
            m_d.dste   = bus.e_dstE;
            m_d.dstm   = bus.E_dstm;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cc_q <= CC_RESET_VAL;
            m_q  <= M_BUBBLE;
        end else begin
            cc_q <= cc_d;
            m_q  <= m_d;
        end
    end

    assign bus.e_valE   = alu_res;
    assign bus.e_cnd    = cnd;
    assign bus.e_dstE   = (bus.E_icode == I_RRMOVQ && !cnd) ? RNONE : bus.E_dste;
    assign bus.cc       = cc_q;
    assign bus.M_status = m_q.status;
    assign bus.M_icode  = m_q.icode;
    assign bus.M_ifun   = m_q.ifun;
    assign bus.M_cnd    = m_q.cnd;
    assign bus.M_vale   = m_q.vale;
    assign bus.M_vala   = m_q.vala;
    assign bus.M_dste   = m_q.dste;
    assign bus.M_dstm   = m_q.dstm;

endmodule
